bsg_nasti_server_resp: RTL and testbench

Server-side read-response packer for the NASTI tunnel. It accepts NASTI R beats from the memory-side slave, checks each burst against the AxLEN captured when the matching AR was forwarded, and packs each beat into a `bsg_nasti_sr_pkt` carrying `last`, `data` and `id`. The packets go onto the tunnel toward the client, where the client response stage unpacks them back into NASTI R. The block owns beat counting, burst-boundary generation, buffering and error flagging for the read-return path.

---
 rtl/bsg_rocket_pkg.sv | 28 ++
 rtl/bsg_fifo_1r1w_small.sv | 55 +++++
 rtl/bsg_nasti_len_tracker.sv | 63 ++++++
 rtl/bsg_nasti_server_resp.sv | 89 ++++++++
 tb/tb_bsg_nasti_server_resp.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_rocket_pkg.sv
// Shared NASTI tunnel types and widths.
// Used by the server/client tunnel stages.
package bsg_rocket_pkg;

  localparam int bsg_nasti_id_width_gp   = 6;
  localparam int bsg_nasti_data_width_gp = 64;
  localparam int bsg_nasti_resp_width_gp = 2;
  localparam int bsg_nasti_len_width_gp  = 8;
  localparam int bsg_tun_dmx_width_gp    = 80;

  typedef struct packed {
    logic [bsg_nasti_id_width_gp-1:0]   id;
    logic [bsg_nasti_data_width_gp-1:0] data;
    logic [bsg_nasti_resp_width_gp-1:0] resp;
    logic                               last;
  } bsg_nasti_r_pkt;

  typedef struct packed {
    logic                               last;
    logic [bsg_nasti_data_width_gp-1:0] data;
    logic [bsg_nasti_id_width_gp-1:0]   id;
  } bsg_nasti_sr_pkt;

  localparam int bsg_nasti_sr_width_gp = $bits(bsg_nasti_sr_pkt);

  typedef logic [bsg_tun_dmx_width_gp-1:0] bsg_tun_dmx_t;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1r1w FIFO, registered storage.
// Ready means not full; no enqueue bypass when full.
module bsg_fifo_1r1w_small #(
  parameter int  els_p = 2,
  parameter type el_t  = logic
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic v_i,
  input  el_t  data_i,
  output logic ready_o,
  output logic v_o,
  output el_t  data_o,
  input  logic yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  el_t              mem [els_p];
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w-1:0] wr_ptr;
  logic [cnt_w-1:0] count;
  logic             enq;
  logic             deq;

  assign ready_o = (count != cnt_w'(els_p));
  assign v_o     = (count != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem[rd_ptr];

  // Storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)
        wr_ptr <= (wr_ptr == ptr_w'(els_p - 1))
                ? '0 : wr_ptr + ptr_w'(1);
      if (deq)
        rd_ptr <= (rd_ptr == ptr_w'(els_p - 1))
                ? '0 : rd_ptr + ptr_w'(1);
      count <= count + cnt_w'(enq) - cnt_w'(deq);
    end
  end

endmodule

// File: rtl/bsg_nasti_len_tracker.sv
// Burst length FIFO and head-burst beat counter.
// Generates last and retires a length on the final beat.
module bsg_nasti_len_tracker
  import bsg_rocket_pkg::*;
#(
  parameter int len_els_p = 4,
  localparam int ow_lp    = $clog2(len_els_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              len_v_i,
  input  logic [bsg_nasti_len_width_gp-1:0] len_i,
  output logic                              len_ready_o,
  output logic                              head_v_o,
  input  logic                              beat_v_i,
  output logic                              gen_last_o,
  output logic [ow_lp-1:0]                  outstanding_o
);

  logic [bsg_nasti_len_width_gp-1:0] head_len;
  logic [bsg_nasti_len_width_gp-1:0] beat_cnt;
  logic                              push;
  logic                              pop;
  logic [ow_lp-1:0]                  out_cnt;

  assign push          = len_v_i & len_ready_o;
  assign gen_last_o    = (beat_cnt == head_len);
  assign pop           = beat_v_i & head_v_o & gen_last_o;
  assign outstanding_o = out_cnt;

  bsg_fifo_1r1w_small #(
    .els_p (len_els_p),
    .el_t  (logic [bsg_nasti_len_width_gp-1:0])
  ) len_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (len_v_i),
    .data_i    (len_i),
    .ready_o   (len_ready_o),
    .v_o       (head_v_o),
    .data_o    (head_len),
    .yumi_i    (pop)
  );

  // Beat counter for the head burst; compare happens before increment.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_cnt <= '0;
    end else if (beat_v_i & head_v_o) begin
      beat_cnt <= gen_last_o ? '0 : beat_cnt + 8'd1;
    end
  end

  // Bursts whose length entry is still held.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + ow_lp'(push) - ow_lp'(pop);
    end
  end

endmodule

// File: rtl/bsg_nasti_server_resp.sv
// NASTI R beat packer for the server side of the tunnel.
// Forwards generated last; flags slave last/resp mismatches.
module bsg_nasti_server_resp
  import bsg_rocket_pkg::*;
#(
  parameter int data_els_p = 2,
  parameter int len_els_p  = 4,
  localparam int ow_lp     = $clog2(len_els_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              len_v_i,
  input  logic [bsg_nasti_len_width_gp-1:0] len_i,
  output logic                              len_ready_o,
  input  logic                              nasti_r_valid_i,
  input  bsg_nasti_r_pkt                    nasti_r_data_i,
  output logic                              nasti_r_ready_o,
  output logic                              resp_v_o,
  output bsg_tun_dmx_t                      resp_data_o,
  input  logic                              resp_yumi_i,
  output logic                              err_len_o,
  output logic                              err_resp_o,
  output logic [ow_lp-1:0]                  outstanding_o
);

  logic            head_v;
  logic            gen_last;
  logic            buf_ready;
  logic            accept;
  bsg_nasti_sr_pkt in_pkt;
  bsg_nasti_sr_pkt out_pkt;

  assign nasti_r_ready_o = head_v & buf_ready;
  assign accept          = nasti_r_valid_i & nasti_r_ready_o;

  bsg_nasti_len_tracker #(
    .len_els_p (len_els_p)
  ) tracker (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .len_v_i       (len_v_i),
    .len_i         (len_i),
    .len_ready_o   (len_ready_o),
    .head_v_o      (head_v),
    .beat_v_i      (accept),
    .gen_last_o    (gen_last),
    .outstanding_o (outstanding_o)
  );

  // Pack the beat; the slave's last and resp are not forwarded.
  always_comb begin
    in_pkt      = '0;
    in_pkt.last = gen_last;
    in_pkt.data = nasti_r_data_i.data;
    in_pkt.id   = nasti_r_data_i.id;
  end

  bsg_fifo_1r1w_small #(
    .els_p (data_els_p),
    .el_t  (bsg_nasti_sr_pkt)
  ) out_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (accept),
    .data_i    (in_pkt),
    .ready_o   (buf_ready),
    .v_o       (resp_v_o),
    .data_o    (out_pkt),
    .yumi_i    (resp_yumi_i)
  );

  // Zero-extend the packet onto the tunnel word.
  always_comb begin
    resp_data_o = '0;
    resp_data_o[bsg_nasti_sr_width_gp-1:0] = out_pkt;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_len_o  <= 1'b0;
      err_resp_o <= 1'b0;
    end else if (accept) begin
      if (nasti_r_data_i.last != gen_last) err_len_o <= 1'b1;
      if (nasti_r_data_i.resp != '0)       err_resp_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_nasti_server_resp.sv
// Bench for bsg_nasti_server_resp.
// Directed plan plus random traffic against a queue model.
module tb_bsg_nasti_server_resp;
  import bsg_rocket_pkg::*;

  localparam int DE = 2;
  localparam int LE = 4;
  localparam int OW = $clog2(LE + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic           len_v = 0;
  logic [7:0]     len = 0;
  logic           len_ready;
  logic           r_valid = 0;
  bsg_nasti_r_pkt r_pkt = '0;
  logic           r_ready;
  logic           resp_v;
  bsg_tun_dmx_t   resp_data;
  logic           yumi = 0;
  logic           err_len;
  logic           err_resp;
  logic [OW-1:0]  outst;

  bsg_nasti_server_resp #(.data_els_p(DE), .len_els_p(LE)) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .len_v_i         (len_v),
    .len_i           (len),
    .len_ready_o     (len_ready),
    .nasti_r_valid_i (r_valid),
    .nasti_r_data_i  (r_pkt),
    .nasti_r_ready_o (r_ready),
    .resp_v_o        (resp_v),
    .resp_data_o     (resp_data),
    .resp_yumi_i     (yumi),
    .err_len_o       (err_len),
    .err_resp_o      (err_resp),
    .outstanding_o   (outst)
  );

  int checks = 0;
  int failures = 0;

  int              lens_q[$];
  bsg_nasti_sr_pkt out_q[$];
  int              beat_idx = 0;
  bit              m_err_len = 0;
  bit              m_err_resp = 0;
  bit              acc = 0;
  bit              lacc = 0;
  bit              yumi_en = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit slave_last();
    if (lens_q.size() == 0) return 1'b0;
    return beat_idx == lens_q[0];
  endfunction

  // One clock: check outputs against the model, advance model, clock.
  task automatic tick();
    bit exp_rdy, exp_lrdy, exp_v, gl;
    bsg_nasti_sr_pkt p;
    bsg_tun_dmx_t ed;
    exp_lrdy = lens_q.size() < LE;
    exp_rdy  = (lens_q.size() > 0) && (out_q.size() < DE);
    exp_v    = out_q.size() > 0;
    yumi     = yumi_en && exp_v;
    chk("len_ready", len_ready, exp_lrdy);
    chk("r_ready", r_ready, exp_rdy);
    chk("resp_v", resp_v, exp_v);
    if (exp_v) begin
      ed = '0;
      ed[bsg_nasti_sr_width_gp-1:0] = out_q[0];
      chk("resp_data", resp_data, ed);
    end
    chk("err_len", err_len, m_err_len);
    chk("err_resp", err_resp, m_err_resp);
    chk("outstanding", outst, lens_q.size());
    acc  = r_valid && exp_rdy;
    lacc = len_v && exp_lrdy;
    if (yumi) void'(out_q.pop_front());
    if (acc) begin
      gl = (beat_idx == lens_q[0]);
      p.last = gl;
      p.data = r_pkt.data;
      p.id   = r_pkt.id;
      out_q.push_back(p);
      if (r_pkt.last != gl) m_err_len = 1;
      if (r_pkt.resp != 0) m_err_resp = 1;
      if (gl) begin
        void'(lens_q.pop_front());
        beat_idx = 0;
      end else begin
        beat_idx++;
      end
    end
    if (lacc) lens_q.push_back(len);
    @(posedge clk);
    #1;
  endtask

  task automatic push_len(logic [7:0] l);
    len_v = 1;
    len = l;
    lacc = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (lacc) break;
    end
    chk("len_push_timeout", lacc, 1);
    len_v = 0;
  endtask

  task automatic send_beat(logic [5:0] id, logic [63:0] d,
                           logic [1:0] rs, logic lst);
    r_valid = 1;
    r_pkt.id = id;
    r_pkt.data = d;
    r_pkt.resp = rs;
    r_pkt.last = lst;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc) break;
    end
    chk("beat_timeout", acc, 1);
    r_valid = 0;
  endtask

  task automatic idle(int n);
    r_valid = 0;
    len_v = 0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 0;
    len_v = 0;
    r_valid = 0;
    yumi = 0;
    yumi_en = 0;
    #1;
    chk("rst_resp_v", resp_v, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_resp", err_resp, 0);
    chk("rst_outstanding", outst, 0);
    chk("rst_len_ready", len_ready, 1);
    lens_q.delete();
    out_q.delete();
    beat_idx = 0;
    m_err_len = 0;
    m_err_resp = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    #2;
    do_reset();

    // 1: four-beat burst, yumi held high
    yumi_en = 1;
    push_len(3);
    for (int b = 1; b <= 4; b++) send_beat(6'd5, 64'(b), 2'd0, b == 4);
    idle(3);
    chk("t1_err_len", err_len, 0);

    // 2: R valid with no length entry is stalled
    r_valid = 1;
    r_pkt = '0;
    r_pkt.id = 6'd9;
    r_pkt.data = 64'hABCD;
    r_pkt.last = 1;
    repeat (10) tick();
    chk("t2_stalled", r_ready, 0);
    len_v = 1;
    len = 0;
    tick();
    len_v = 0;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) tick();
    chk("t2_accept", acc, 1);
    r_valid = 0;
    idle(3);

    // 3: four bursts fill the length FIFO
    yumi_en = 1;
    push_len(0);
    push_len(1);
    push_len(0);
    push_len(2);
    chk("t3_len_full", len_ready, 0);
    chk("t3_outstanding", outst, 4);
    for (int b = 0; b < 7; b++)
      send_beat(6'd2, 64'h100 + 64'(b), 2'd0, slave_last());
    idle(3);

    // 256-beat burst: 8-bit counter must reach 255
    push_len(8'd255);
    for (int b = 0; b < 256; b++)
      send_beat(6'd7, 64'(b), 2'd0, slave_last());
    idle(3);
    chk("t255_outstanding", outst, 0);

    // 4: slave last early; generated last forwarded
    push_len(1);
    send_beat(6'd3, 64'hAA, 2'd0, 1'b1);
    send_beat(6'd3, 64'hBB, 2'd0, 1'b0);
    idle(3);
    chk("t4_err_len", err_len, 1);

    // 5: nonzero resp
    push_len(0);
    send_beat(6'd4, 64'hCC, 2'd2, 1'b1);
    idle(3);
    chk("t5_err_resp", err_resp, 1);

    // 6: buffer backpressure, then drain, then reset mid-burst
    yumi_en = 0;
    push_len(7);
    k = 0;
    r_valid = 1;
    for (int i = 0; i < 6; i++) begin
      r_pkt.id = 6'd1;
      r_pkt.data = 64'h700 + 64'(k);
      r_pkt.resp = 0;
      r_pkt.last = slave_last();
      tick();
      if (acc) k++;
    end
    chk("t6_stall_count", k, 2);
    chk("t6_ready_low", r_ready, 0);
    yumi_en = 1;
    while (k < 8) begin
      send_beat(6'd1, 64'h700 + 64'(k), 2'd0, slave_last());
      k++;
    end
    idle(3);
    push_len(7);
    for (int b = 0; b < 3; b++)
      send_beat(6'd1, 64'h800 + 64'(b), 2'd0, slave_last());
    do_reset();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      len_v = ($urandom_range(3) == 0);
      len = 8'($urandom_range(5));
      r_valid = ($urandom_range(9) < 7);
      r_pkt.id = 6'($urandom);
      r_pkt.data = {$urandom, $urandom};
      r_pkt.resp = ($urandom_range(40) == 0) ? 2'd2 : 2'd0;
      r_pkt.last = slave_last() ^ ($urandom_range(40) == 0);
      yumi_en = ($urandom_range(9) < 7);
      tick();
    end
    len_v = 0;
    yumi_en = 1;
    for (int c = 0; c < 200 && lens_q.size() > 0; c++)
      send_beat(6'd0, 64'(c), 2'd0, slave_last());
    idle(4);
    chk("final_outstanding", outst, 0);
    chk("final_resp_v", resp_v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
